x_count_detect: RTL and testbench

X_COUNT_DETECT -- requirements
Module: x_count_detect

---
 rtl/x_count_pkg.sv | 15 +
 rtl/x_count_detect_sat_counter.sv | 32 +++
 rtl/x_count_detect.sv | 99 +++++++++
 tb/tb_x_count_detect.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/x_count_pkg.sv
// Shared definitions for the x-count detector: state encoding and the
// count-register width helper.
package x_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int target);
    return (target <= 2) ? 1 : $clog2(target);
  endfunction

endpackage

// File: rtl/x_count_detect_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         ovf
);

  localparam logic [W-1:0] Q_MAX = '1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == Q_MAX) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      q <= sat_inc(q);
      if (q == Q_MAX) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/x_count_detect.sv
// Counts accepted x=1 samples and flags a detection (Mealy y, registered
// done) every TARGET of them; detections are tallied in a saturating counter.
module x_count_detect
  import x_count_pkg::*;
#(
  parameter  int TARGET    = 3,
  parameter  int HOLD_ZERO = 1,
  parameter  int HIT_W     = 8,
  localparam int CW        = cnt_width(TARGET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             x,
  output logic             y,
  output logic             done,
  output logic [1:0]       state,
  output logic [CW-1:0]    cnt,
  output logic [HIT_W-1:0] hits,
  output logic             hit_ovf
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TARGET - 1);

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    y         = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (!(state_q inside {IDLE, COUNT, DONE})) begin
      // Unused encoding recovers to IDLE even while sampling is disabled
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          cnt_nxt = x ? CNT_ONE : '0;
          if (x) state_nxt = COUNT;
        end
        COUNT: begin
          if (x) begin
            if (cnt_q == CNT_LAST) begin
              y         = 1'b1;
              state_nxt = DONE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q + CNT_ONE;
            end
          end else if (HOLD_ZERO == 0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        DONE: begin
          // A 1 here already counts toward the next detection
          state_nxt = x ? COUNT : IDLE;
          cnt_nxt   = x ? CNT_ONE : '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign done  = (state_q == DONE);

  sat_counter #(
    .W (HIT_W)
  ) u_hits (
    .clk (clk),
    .rst (rst),
    .inc (y),
    .clr (clr),
    .q   (hits),
    .ovf (hit_ovf)
  );

endmodule

// File: tb/tb_x_count_detect.sv
// Scoreboard bench: four detector instances share one stimulus stream;
// expected values are queued per instance and checked at the falling edge.
module tb_x_count_detect;

  logic clk, rst, en, clr, x;

  logic       y0, done0, ovf0;
  logic [1:0] st0, cnt0;
  logic [7:0] hits0;
  logic       y1, done1, ovf1;
  logic [1:0] st1, cnt1;
  logic [7:0] hits1;
  logic       y2, done2, ovf2;
  logic [1:0] st2, cnt2;
  logic [1:0] hits2;
  logic       y3, done3, ovf3;
  logic [1:0] st3;
  logic [2:0] cnt3;
  logic [7:0] hits3;

  x_count_detect #(.TARGET(3), .HOLD_ZERO(1), .HIT_W(8)) d0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y0), .done(done0),
    .state(st0), .cnt(cnt0), .hits(hits0), .hit_ovf(ovf0));
  x_count_detect #(.TARGET(3), .HOLD_ZERO(0), .HIT_W(8)) d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y1), .done(done1),
    .state(st1), .cnt(cnt1), .hits(hits1), .hit_ovf(ovf1));
  x_count_detect #(.TARGET(3), .HOLD_ZERO(1), .HIT_W(2)) d2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y2), .done(done2),
    .state(st2), .cnt(cnt2), .hits(hits2), .hit_ovf(ovf2));
  x_count_detect #(.TARGET(5), .HOLD_ZERO(1), .HIT_W(8)) d3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y3), .done(done3),
    .state(st3), .cnt(cnt3), .hits(hits3), .hit_ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    sel;
    string name;
    logic  y;
    int    st;
    int    cnt;
    int    hits;
    logic  ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // HIT_W=2 run of 13 consecutive ones, TARGET=3
  int e_st  [13] = '{0,1,1,2,1,1,2,1,1,2,1,1,2};
  int e_cnt [13] = '{0,1,2,0,1,2,0,1,2,0,1,2,0};
  int e_y   [13] = '{0,0,1,0,0,1,0,0,1,0,0,1,0};
  int e_hits[13] = '{0,0,0,1,1,1,2,2,2,3,3,3,3};
  int e_ovf [13] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};

  task automatic push(input int sel, input string name, input logic ey,
                      input int est, input int ecnt, input int ehits, input logic eovf);
    exp_t e;
    e.sel = sel; e.name = name; e.y = ey; e.st = est;
    e.cnt = ecnt; e.hits = ehits; e.ovf = eovf;
    sb.push_back(e);
  endtask

  task automatic drive(input logic ix, input logic ien, input logic iclr);
    @(posedge clk);
    #1;
    rst = 1'b1; x = ix; en = ien; clr = iclr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1; x = 1'b1; clr = 1'b0;
    for (int s = 0; s < 4; s++) push(s, "reset", 1'b0, 0, 0, 0, 1'b0);
  endtask

  logic ay, ad, aovf;
  int   ast, acnt, ahits;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin ay = y0; ad = done0; aovf = ovf0; ast = int'(st0); acnt = int'(cnt0); ahits = int'(hits0); end
        1:       begin ay = y1; ad = done1; aovf = ovf1; ast = int'(st1); acnt = int'(cnt1); ahits = int'(hits1); end
        2:       begin ay = y2; ad = done2; aovf = ovf2; ast = int'(st2); acnt = int'(cnt2); ahits = int'(hits2); end
        default: begin ay = y3; ad = done3; aovf = ovf3; ast = int'(st3); acnt = int'(cnt3); ahits = int'(hits3); end
      endcase
      n_cmp++;
      if (ay !== e.y || ad !== (e.st == 2) || ast != e.st || acnt != e.cnt ||
          ahits != e.hits || aovf !== e.ovf) begin
        n_err++;
        $display("FAIL %s dut%0d: got y=%0b done=%0b st=%0d cnt=%0d hits=%0d ovf=%0b, want y=%0b done=%0b st=%0d cnt=%0d hits=%0d ovf=%0b",
                 e.name, e.sel, ay, ad, ast, acnt, ahits, aovf,
                 e.y, (e.st == 2), e.st, e.cnt, e.hits, e.ovf);
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;

    // basic detection then return to IDLE
    do_reset();
    drive(1, 1, 0); push(0, "A1", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(0, "A2", 0, 1, 1, 0, 0);
    drive(1, 1, 0); push(0, "A3", 1, 1, 2, 0, 0);
    drive(0, 1, 0); push(0, "A4", 0, 2, 0, 1, 0);
    drive(0, 1, 0); push(0, "A5", 0, 0, 0, 1, 0);

    // zeros inside a run: hold (d0) versus clear (d1)
    do_reset();
    drive(1, 1, 0); push(0, "B1h", 0, 0, 0, 0, 0); push(1, "B1c", 0, 0, 0, 0, 0);
    drive(0, 1, 0); push(0, "B2h", 0, 1, 1, 0, 0); push(1, "B2c", 0, 1, 1, 0, 0);
    drive(0, 1, 0); push(0, "B3h", 0, 1, 1, 0, 0); push(1, "B3c", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(0, "B4h", 0, 1, 1, 0, 0); push(1, "B4c", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(0, "B5h", 1, 1, 2, 0, 0); push(1, "B5c", 0, 1, 1, 0, 0);
    drive(0, 1, 0); push(0, "B6h", 0, 2, 0, 1, 0); push(1, "B6c", 0, 1, 2, 0, 0);

    // back-to-back detections
    do_reset();
    drive(1, 1, 0); push(0, "C1", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(0, "C2", 0, 1, 1, 0, 0);
    drive(1, 1, 0); push(0, "C3", 1, 1, 2, 0, 0);
    drive(1, 1, 0); push(0, "C4", 0, 2, 0, 1, 0);
    drive(1, 1, 0); push(0, "C5", 0, 1, 1, 1, 0);
    drive(1, 1, 0); push(0, "C6", 1, 1, 2, 1, 0);
    drive(0, 1, 0); push(0, "C7", 0, 2, 0, 2, 0);
    drive(0, 1, 0); push(0, "C8", 0, 0, 0, 2, 0);

    // enable gating, including a frozen DONE
    do_reset();
    drive(1, 1, 0); push(0, "D1", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(0, "D2", 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0); push(0, "D_en0", 0, 1, 2, 0, 0);
    end
    drive(1, 1, 0); push(0, "D7", 1, 1, 2, 0, 0);
    drive(1, 0, 0); push(0, "D8", 0, 2, 0, 1, 0);
    drive(1, 0, 0); push(0, "D9", 0, 2, 0, 1, 0);
    drive(1, 1, 0); push(0, "D10", 0, 2, 0, 1, 0);
    drive(0, 1, 0); push(0, "D11", 0, 1, 1, 1, 0);

    // hit saturation with HIT_W=2, then clear suppressing a would-be detect
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1, 1, 0);
      push(2, $sformatf("E%0d", i + 1), logic'(e_y[i]), e_st[i], e_cnt[i], e_hits[i], logic'(e_ovf[i]));
    end
    drive(1, 1, 0); push(2, "E14", 0, 1, 1, 3, 1);
    drive(1, 1, 1); push(2, "E_clr", 0, 1, 2, 3, 1);
    drive(0, 1, 0); push(2, "E_post", 0, 0, 0, 0, 0);

    // asynchronous reset mid-count, TARGET=5
    do_reset();
    drive(1, 1, 0); push(3, "F1", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(3, "F2", 0, 1, 1, 0, 0);
    drive(0, 1, 0); push(3, "F3", 0, 1, 2, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; x = 1'b1; en = 1'b1; clr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    push(3, "F_async", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(3, "F5", 0, 0, 0, 0, 0);
    drive(1, 1, 0); push(3, "F6", 0, 1, 1, 0, 0);
    drive(1, 1, 0); push(3, "F7", 0, 1, 2, 0, 0);
    drive(1, 1, 0); push(3, "F8", 0, 1, 3, 0, 0);
    drive(1, 1, 0); push(3, "F9", 1, 1, 4, 0, 0);
    drive(0, 1, 0); push(3, "F10", 0, 2, 0, 1, 0);

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
        @(negedge clk);
        #1;
        guard++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
